// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared constants and types for the ALU sequencer:
//   - MIPS R-type funct codes handled by the sequencer
//   - 3-bit op codes understood by the gate-level ALU
//   - sequencer FSM state encoding
// Optional feature macro: SIGNED_MULT_EN (adds the operand magnitude helper
// used by signed multiply).
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MULT  = 6'h18;

  // ALU op codes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_NEG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

`ifdef SIGNED_MULT_EN
  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction
`endif

endpackage

// File: rtl/alu_funct_decode.sv
// -----------------------------------------------------------------------------
// alu_funct_decode
// Combinational funct decoder for the ALU sequencer.
// Ports:
//   i_funct   in  6  R-type funct code
//   o_alu_op  out 3  ALU op for single-cycle functs (ADD for multiplies)
//   o_ovf_en  out 1  signed overflow is reported (add/sub)
//   o_is_mul  out 1  funct runs the shift-add multiply
//   o_err     out 1  funct is not supported
// Optional feature macro: SIGNED_MULT_EN (funct 0x18 mult decodes as multiply;
// otherwise it is unsupported).
// -----------------------------------------------------------------------------
module alu_funct_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_ovf_en,
  output logic       o_is_mul,
  output logic       o_err
);

  always_comb begin
    o_alu_op = OP_AND;
    o_ovf_en = 1'b0;
    o_is_mul = 1'b0;
    o_err    = 1'b0;
    case (i_funct)
      F_ADD:   begin o_alu_op = OP_ADD; o_ovf_en = 1'b1; end
      F_ADDU:  o_alu_op = OP_ADD;
      F_SUB:   begin o_alu_op = OP_SUB; o_ovf_en = 1'b1; end
      F_SUBU:  o_alu_op = OP_SUB;
      F_AND:   o_alu_op = OP_AND;
      F_OR:    o_alu_op = OP_OR;
      F_SLT:   o_alu_op = OP_SLT;
      F_MULTU: begin o_alu_op = OP_ADD; o_is_mul = 1'b1; end
`ifdef SIGNED_MULT_EN
      F_MULT:  begin o_alu_op = OP_ADD; o_is_mul = 1'b1; end
`endif
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle execute front-end for the external 32-bit gate-level ALU.
// Accepts an R-type request, drives the ALU for one cycle (logic/arith ops) or
// ITERS cycles (shift-add unsigned multiply using the ALU adder), and returns
// lo/hi/overflow/error.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and data until that edge; ready does not depend on
// valid. in_ready is high only in IDLE, out_valid only in DONE, so a request is
// never accepted in the cycle its predecessor's result is consumed.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        request handshake (funct, op_a, op_b)
//   out_valid/out_ready      result handshake (out_lo, out_hi, out_ovf, out_err)
//   alu_a/alu_b/alu_op       ALU operands and op (0 outside EXEC/MUL)
//   alu_r/alu_v/alu_c31      ALU result, overflow, carry out of bit 31
//   dbg_state                current FSM state (state_t encoding)
// Optional feature macro: SIGNED_MULT_EN (funct 0x18 signed multiply with a
// trailing NEG state; undefined -> 0x18 is an unsupported funct).
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ITERS = 32  // must equal the operand width (32)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        out_ovf,
  output logic        out_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_v,
  input  logic        alu_c31,
  output logic [2:0]  dbg_state
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t r_state;
  state_t w_next;

  // Request registers; r_a doubles as the multiplier shift register and
  // r_b as the multiplicand during MUL.
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;
  logic             r_ovf_en;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_ovf;
  logic        r_err;

`ifdef SIGNED_MULT_EN
  logic r_signed;  // request was mult: pass through NEG after MUL
  logic r_neg;     // operand signs differed: negate the product in NEG
  logic w_is_smul;
  assign w_is_smul = (funct == F_MULT);
`endif

  logic [2:0] w_dec_op;
  logic       w_dec_ovf_en;
  logic       w_dec_is_mul;
  logic       w_dec_err;

  alu_funct_decode u_decode (
    .i_funct  (funct),
    .o_alu_op (w_dec_op),
    .o_ovf_en (w_dec_ovf_en),
    .o_is_mul (w_dec_is_mul),
    .o_err    (w_dec_err)
  );

  logic w_accept;
  logic w_last;
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_LAST);

  // One shift-add step: the sum (or the unchanged accumulator) is shifted
  // right as a 65-bit {carry, acc, mplr} chain.
  logic        w_c;
  logic [31:0] w_s;
  logic [31:0] w_acc_nxt;
  logic [31:0] w_mplr_nxt;

  always_comb begin
    if (r_a[0]) begin
      w_c = alu_c31;
      w_s = alu_r;
    end else begin
      w_c = 1'b0;
      w_s = r_acc;
    end
    w_acc_nxt  = {w_c, w_s[31:1]};
    w_mplr_nxt = {w_s[0], r_a[31:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_dec_err)         w_next = S_DONE;
          else if (w_dec_is_mul) w_next = S_MUL;
          else                   w_next = S_EXEC;
        end
      end
      S_EXEC: w_next = S_DONE;
      S_MUL: begin
        if (w_last) begin
`ifdef SIGNED_MULT_EN
          w_next = r_signed ? S_NEG : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef SIGNED_MULT_EN
      S_NEG:  w_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_op    = 3'b000;
    case (r_state)
      S_EXEC: begin
        alu_a  = r_a;
        alu_b  = r_b;
        alu_op = r_op;
      end
      S_MUL: begin
        alu_a  = r_acc;
        alu_b  = r_b;
        alu_op = OP_ADD;
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_op     <= 3'b000;
      r_ovf_en <= 1'b0;
      r_acc    <= 32'd0;
      r_cnt    <= '0;
      r_lo     <= 32'd0;
      r_hi     <= 32'd0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
`ifdef SIGNED_MULT_EN
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_op     <= w_dec_op;
            r_ovf_en <= w_dec_ovf_en;
            r_acc    <= 32'd0;
            r_cnt    <= '0;
`ifdef SIGNED_MULT_EN
            r_signed <= w_is_smul;
            r_neg    <= w_is_smul && (op_a[31] ^ op_b[31]);
            if (w_is_smul) begin
              r_a <= mag32(op_a);
              r_b <= mag32(op_b);
            end
`endif
            if (w_dec_err) begin
              r_lo  <= 32'd0;
              r_hi  <= 32'd0;
              r_ovf <= 1'b0;
              r_err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_lo  <= alu_r;
          r_hi  <= 32'd0;
          r_ovf <= r_ovf_en && alu_v;
          r_err <= 1'b0;
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= w_mplr_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi  <= w_acc_nxt;
            r_lo  <= w_mplr_nxt;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end
        end
`ifdef SIGNED_MULT_EN
        S_NEG: begin
          if (r_neg) {r_hi, r_lo} <= ~{r_hi, r_lo} + 64'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_lo    = r_lo;
  assign out_hi    = r_hi;
  assign out_ovf   = r_ovf;
  assign out_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. The external ALU is modelled
// behaviourally; expected results come from plain 32/64-bit arithmetic.
// Build with SIGNED_MULT_EN defined to cover the signed multiply option.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  funct = 6'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_lo, out_hi;
  logic        out_ovf, out_err;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_v, alu_c31;
  logic [2:0]  dbg_state;

  alu_sequencer #(.ITERS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .out_ovf(out_ovf), .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_v(alu_v), .alu_c31(alu_c31),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  always_comb begin
    alu_r   = 32'd0;
    alu_v   = 1'b0;
    alu_c31 = 1'b0;
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b010: begin
        {alu_c31, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      3'b110: begin
        {alu_c31, alu_r} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      3'b111: alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: ;
    endcase
  end

  // ---------------- counters / check helper ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed result: {lat[7:0], err, ovf, hi[31:0], lo[31:0]}
  function automatic logic [73:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] lo, hi;
    logic        ovf, err;
    logic [7:0]  lat;
    logic [63:0] p;
    lo = 0; hi = 0; ovf = 0; err = 0; lat = 8'd2;
    case (f)
      6'h20: begin lo = a + b; ovf = (a[31] == b[31]) && (lo[31] != a[31]); end
      6'h21: lo = a + b;
      6'h22: begin lo = a - b; ovf = (a[31] != b[31]) && (lo[31] != a[31]); end
      6'h23: lo = a - b;
      6'h24: lo = a & b;
      6'h25: lo = a | b;
      6'h2A: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h19: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; lat = 8'd33; end
`ifdef SIGNED_MULT_EN
      6'h18: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        {hi, lo} = p;
        lat = 8'd34;
      end
`endif
      default: begin err = 1'b1; lat = 8'd1; end
    endcase
    return {lat, err, ovf, hi, lo};
  endfunction

  function automatic logic [2:0] ref_op(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 3'b010;
      6'h22, 6'h23: return 3'b110;
      6'h25:        return 3'b001;
      6'h2A:        return 3'b111;
      default:      return 3'b000;
    endcase
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [73:0] exp_q[$];   // expected results of accepted requests
  logic        busy = 1'b0;
  int          cur_k = 0;
  int          cur_lat = 0;
  int          cur_nalu = 0;
  logic [73:0] cur_exp = '0;
  logic [31:0] cur_a = 0, cur_b = 0;
  logic [2:0]  cur_op = 0;
  logic        due, alu_act;

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      exp_q.delete();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outs", {out_err, out_ovf, out_hi, out_lo}, 0);
      chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    end else begin
      chk("in_ready", in_ready, !busy);
      due = busy && (cyc >= cur_k + cur_lat);
      chk("out_valid", out_valid, due);
      if (due && out_valid) begin
        chk("out_lo", out_lo, cur_exp[31:0]);
        chk("out_hi", out_hi, cur_exp[63:32]);
        chk("out_ovf", out_ovf, cur_exp[64]);
        chk("out_err", out_err, cur_exp[65]);
      end
      alu_act = busy && (cyc > cur_k) && (cyc <= cur_k + cur_nalu);
      if (!alu_act)
        chk("alu_idle", {alu_op, alu_a, alu_b}, 0);
      else if (cur_nalu == 1)
        chk("alu_exec", {alu_op, alu_a, alu_b}, {cur_op, cur_a, cur_b});
      else
        chk("alu_mul_op", alu_op, 3'b010);

      // Transfers happening at the coming rising edge.
      if (busy && out_valid && out_ready) begin
        busy = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!busy && in_valid && in_ready) begin
        cur_exp  = ref_model(funct, op_a, op_b);
        exp_q.push_back(cur_exp);
        cur_lat  = int'(cur_exp[73:66]);
        cur_nalu = (cur_lat == 1) ? 0 : (cur_lat == 2) ? 1 : 32;
        cur_k    = cyc;
        cur_a    = op_a;
        cur_b    = op_b;
        cur_op   = ref_op(funct);
        busy     = 1'b1;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 2;  // 0 random, 1 forced low, 2 forced high
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end aligned to #1 after a rising edge.
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int   t;
    logic acc;
    t = 0; acc = 1'b0;
    funct = f; op_a = a; op_b = b; in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: request %0h not accepted within %0d cycles", f, t);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: result not consumed within %0d cycles", t);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_checks++; n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [5:0] flist [10];
  int         t;

  initial begin
    flist = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h18, 6'h00};

    // Hand-computed values pin the reference model itself.
    chk("pin_add",   ref_model(6'h20, 32'h7FFF_FFFF, 32'h1), {8'd2, 1'b0, 1'b1, 32'h0, 32'h8000_0000});
    chk("pin_addu",  ref_model(6'h21, 32'h7FFF_FFFF, 32'h1), {8'd2, 1'b0, 1'b0, 32'h0, 32'h8000_0000});
    chk("pin_sub",   ref_model(6'h22, 32'd5, 32'd7),         {8'd2, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE});
    chk("pin_slt",   ref_model(6'h2A, 32'hFFFF_FFFF, 32'h1), {8'd2, 1'b0, 1'b0, 32'h0, 32'h1});
    chk("pin_multu", ref_model(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        {8'd33, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h1});
    chk("pin_multu2", ref_model(6'h19, 32'h0001_0000, 32'h0001_0000),
        {8'd33, 1'b0, 1'b0, 32'h1, 32'h0});
    chk("pin_err",   ref_model(6'h00, 32'h1234, 32'h5678),   {8'd1, 1'b1, 1'b0, 32'h0, 32'h0});
    chk("pin_and",   ref_model(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00),
        {8'd2, 1'b0, 1'b0, 32'h0, 32'hF000_F000});
`ifdef SIGNED_MULT_EN
    chk("pin_mult",  ref_model(6'h18, 32'hFFFF_FFFE, 32'd3),
        {8'd34, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
`else
    chk("pin_mult",  ref_model(6'h18, 32'hFFFF_FFFE, 32'd3), {8'd1, 1'b1, 1'b0, 32'h0, 32'h0});
`endif

    // Reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed requests
    send(6'h20, 32'h7FFF_FFFF, 32'h1);
    send(6'h21, 32'h7FFF_FFFF, 32'h1);
    send(6'h22, 32'd5, 32'd7);
    send(6'h2A, 32'hFFFF_FFFF, 32'h1);
    send(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(6'h19, 32'h0001_0000, 32'h0001_0000);
    send(6'h00, 32'h1234, 32'h5678);
    send(6'h18, 32'hFFFF_FFFE, 32'd3);
    wait_idle();

    // Backpressure: result held, a second request pending and not accepted
    rdy_mode = 1;
    send(6'h24, 32'hA5A5_A5A5, 32'h0FF0_0FF0);
    t = 0;
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", out_valid, 1);
    @(posedge clk); #1;
    funct = 6'h25; op_a = 32'h1111_0000; op_b = 32'h0000_2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_lo", out_lo, 32'hA5A5_A5A5 & 32'h0FF0_0FF0);
      @(posedge clk); #1;
    end
    rdy_mode = 2;
    send(6'h25, 32'h1111_0000, 32'h0000_2222);
    wait_idle();

    // Reset during multiply iteration 10
    rdy_mode = 0;
    send(6'h19, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_alu", {alu_op, alu_a, alu_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [5:0] f;
      f = flist[$urandom_range(0, 9)];
      if (f == 6'h00) f = 6'($urandom_range(0, 63));
      send(f, rnd_op(), rnd_op());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
